// File: rtl/cam_sync_responder.sv
// Camera-side sync responder: arms the projector, sequences one exposure/readout
// per synchronised strobe edge, counts frames and flags timeout/overrun/marker errors.
`timescale 1ns/1ps
module cam_sync_responder #(
  parameter int NUM_FRAMES      = 488,
  parameter int EXPOSURE_CYCLES = 50000,
  parameter int READOUT_CYCLES  = 100000,
  parameter int ARM_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int MARKER_PHASE    = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        strobe_in,
  input  logic        marker_in,
  output logic        trigger_out,
  output logic        frame_ready_out,
  output logic        capture,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic        marker_err
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_STROBE, EXPOSE, READOUT, DONE, ERROR} state_t;

  localparam logic [31:0] ARM_LAST = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] EXP_LAST = 32'(EXPOSURE_CYCLES - 1);
  localparam logic [31:0] RD_LAST  = 32'(READOUT_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] FC_LAST  = 16'(NUM_FRAMES - 1);
  localparam logic [2:0]  MK_PHASE = 3'(MARKER_PHASE);

  state_t      state, state_nx;
  logic [2:0]  strobe_sync;
  logic [1:0]  marker_sync;
  logic        strobe_edge;
  logic [31:0] phase_cnt, timeout_cnt;
  logic        accept, fc_inc, clr_run, in_flight;

  // strobe_sync[2] is only the edge-detect delay; [1] is the synchronised level
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      strobe_sync <= '0;
      marker_sync <= '0;
    end else begin
      strobe_sync <= {strobe_sync[1:0], strobe_in};
      marker_sync <= {marker_sync[0], marker_in};
    end
  end

  assign strobe_edge = strobe_sync[1] & ~strobe_sync[2];
  assign in_flight   = (state == EXPOSE) || (state == READOUT);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fc_inc   = 1'b0;
    clr_run  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERROR:
          if (start) begin
            state_nx = ARM;
            clr_run  = 1'b1;
          end
        ARM:
          if (phase_cnt == ARM_LAST) state_nx = WAIT_STROBE;
        WAIT_STROBE:
          if (timeout_cnt == TO_LAST) state_nx = ERROR;
          else if (strobe_edge) begin
            state_nx = EXPOSE;
            accept   = 1'b1;
          end
        EXPOSE:
          if (phase_cnt == EXP_LAST) state_nx = READOUT;
        READOUT:
          if (phase_cnt == RD_LAST) begin
            fc_inc   = 1'b1;
            state_nx = (frame_count == FC_LAST) ? DONE : WAIT_STROBE;
          end
        default: state_nx = IDLE;
      endcase
    end
  end

  // counters restart on every state change, so each phase is timed from its own entry
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt   <= '0;
      timeout_cnt <= '0;
      capture     <= 1'b0;
      frame_count <= '0;
      overrun_err <= 1'b0;
      marker_err  <= 1'b0;
    end else begin
      phase_cnt   <= (state_nx != state) ? 32'd0 : phase_cnt + 32'd1;
      timeout_cnt <= (state_nx != state) ? 32'd0 : timeout_cnt + 32'd1;
      capture     <= accept;
      if (clr_run) begin
        frame_count <= '0;
        overrun_err <= 1'b0;
        marker_err  <= 1'b0;
      end else begin
        if (fc_inc) frame_count <= frame_count + 16'd1;
        if (strobe_edge && !abort && in_flight) overrun_err <= 1'b1;
        if (accept && (marker_sync[1] != (frame_count[2:0] == MK_PHASE))) marker_err <= 1'b1;
      end
    end
  end

  assign busy            = (state == ARM) || (state == WAIT_STROBE) || in_flight;
  assign trigger_out     = busy;
  assign frame_ready_out = (state == WAIT_STROBE) || (state == EXPOSE);
  assign done            = (state == DONE);
  assign timeout_err     = (state == ERROR);

endmodule

// File: tb/tb_cam_sync_responder.sv
// Bench for cam_sync_responder: directed scenarios plus random soup, all checked
// cycle-by-cycle against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_cam_sync_responder;
  localparam int NF = 10, EXP = 10, RD = 20, ARMC = 4, TO = 100, MP = 1;

  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b0, start = 1'b0, abort = 1'b0, strobe_in = 1'b0, marker_in = 1'b0;
  logic trigger_out, frame_ready_out, capture, busy, done, timeout_err, overrun_err, marker_err;
  logic [15:0] frame_count;

  int n_assert = 0, n_fail = 0;
  bit chk_en = 1'b0;

  cam_sync_responder #(.NUM_FRAMES(NF), .EXPOSURE_CYCLES(EXP), .READOUT_CYCLES(RD),
    .ARM_CYCLES(ARMC), .TIMEOUT_CYCLES(TO), .MARKER_PHASE(MP)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .abort(abort),
    .strobe_in(strobe_in), .marker_in(marker_in), .trigger_out(trigger_out),
    .frame_ready_out(frame_ready_out), .capture(capture), .frame_count(frame_count),
    .busy(busy), .done(done), .timeout_err(timeout_err), .overrun_err(overrun_err),
    .marker_err(marker_err));

  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ARM, M_WAIT, M_EXP, M_RD, M_DONE, M_ERR} mmode_t;
  mmode_t m_mode = M_IDLE, m_nxt;
  int  m_frames = 0, cyc = 0, entry = 0, el;
  bit  m_ovr = 0, m_mrk = 0, m_cap = 0, m_edge, m_mk;
  bit [2:0] st_h = '0, mk_h = '0;

  // durations are measured as (current cycle - cycle the mode was entered)
  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_frames = 0; m_ovr = 0; m_mrk = 0; m_cap = 0;
      st_h = '0; mk_h = '0; cyc = 0; entry = 0;
    end else begin
      cyc++;
      el = cyc - entry;
      m_edge = st_h[1] & ~st_h[2];
      m_mk = mk_h[1];
      m_nxt = m_mode;
      m_cap = 0;
      if (abort) m_nxt = M_IDLE;
      else case (m_mode)
        M_IDLE, M_DONE, M_ERR:
          if (start) begin m_nxt = M_ARM; m_frames = 0; m_ovr = 0; m_mrk = 0; end
        M_ARM: if (el == ARMC) m_nxt = M_WAIT;
        M_WAIT:
          if (el == TO) m_nxt = M_ERR;
          else if (m_edge) begin
            m_nxt = M_EXP; m_cap = 1;
            if (m_mk != ((m_frames % 8) == MP)) m_mrk = 1;
          end
        M_EXP: begin
          if (m_edge) m_ovr = 1;
          if (el == EXP) m_nxt = M_RD;
        end
        M_RD: begin
          if (m_edge) m_ovr = 1;
          if (el == RD) begin
            m_frames++;
            m_nxt = (m_frames == NF) ? M_DONE : M_WAIT;
          end
        end
        default: m_nxt = M_IDLE;
      endcase
      if (m_nxt != m_mode) entry = cyc;
      m_mode = m_nxt;
      st_h = {st_h[1:0], strobe_in};
      mk_h = {mk_h[1:0], marker_in};
    end
  end

  function automatic logic [23:0] model_vec();
    bit act;
    act = (m_mode == M_ARM) || (m_mode == M_WAIT) || (m_mode == M_EXP) || (m_mode == M_RD);
    return {act, (m_mode == M_WAIT) || (m_mode == M_EXP), m_cap, act,
            m_mode == M_DONE, m_mode == M_ERR, m_ovr, m_mrk, 16'(m_frames)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {trigger_out, frame_ready_out, capture, busy, done, timeout_err,
            overrun_err, marker_err, frame_count};
  endfunction

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      n_assert++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: actual %h required %h", $time, dut_vec(), model_vec());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(1); abort = 1'b0;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return frame_ready_out;
      1: return !frame_ready_out;
      2: return done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input string nm);
    int n = 0;
    while (!cond(which) && n < 400) begin tick(1); n++; end
    n_assert++;
    if (!cond(which)) begin
      n_fail++;
      $display("FAIL wait_%s: actual 0 required 1 within 400 cycles", nm);
    end
  endtask

  // mk < 0 drives the correct marker for the frame about to be captured
  task automatic strobe_pulse(input int mk, input int w);
    marker_in = (mk < 0) ? ((m_frames % 8) == MP) : mk[0];
    strobe_in = 1'b1; tick(w); strobe_in = 1'b0; tick(3);
  endtask

  task automatic frames_loop(input int n);
    for (int f = 0; f < n; f++) begin
      wait_until(0, "ready");
      tick($urandom_range(0, 5));
      strobe_pulse(-1, $urandom_range(1, 3));
      wait_until(1, "readout");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, hold;
    tick(3);
    check("reset_outs", 32'(dut_vec()), 32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // nominal run with correct markers
    pulse_start();
    check("arm_trigger", {31'd0, trigger_out}, 32'd1);
    check("arm_ready_low", {31'd0, frame_ready_out}, 32'd0);
    cnt = 0;
    while (!frame_ready_out && cnt < 50) begin tick(1); cnt++; end
    check("arm_len", cnt, ARMC);
    frames_loop(NF);
    wait_until(2, "done");
    check("nom_count", 32'(frame_count), NF);
    check("nom_model_count", m_frames, 10);
    check("nom_flags", {29'd0, trigger_out, overrun_err, marker_err}, 32'd0);

    // timeout from DONE
    pulse_start();
    wait_until(0, "to_ready");
    cnt = 0;
    while (!timeout_err && cnt < 300) begin tick(1); cnt++; end
    check("timeout_len", cnt, TO);
    check("timeout_lines", {30'd0, trigger_out, frame_ready_out}, 32'd0);
    pulse_start();
    check("timeout_clear", {30'd0, timeout_err, trigger_out}, 32'd1);

    // overrun: second strobe a few clocks into EXPOSE
    wait_until(0, "ov_ready");
    strobe_pulse(-1, 1);
    tick(3);
    strobe_pulse(-1, 1);
    check("overrun_set", {31'd0, overrun_err}, 32'd1);
    wait_until(1, "ov_readout");
    wait_until(0, "ov_ready2");
    check("overrun_count", 32'(frame_count), 32'd1);
    frames_loop(1);
    wait_until(0, "ov_ready3");
    check("overrun_count2", 32'(frame_count), 32'd2);

    // abort mid-READOUT at frame_count 2
    strobe_pulse(-1, 2);
    wait_until(1, "ab_readout");
    tick(5);
    pulse_abort();
    check("abort_lines", {29'd0, trigger_out, frame_ready_out, busy}, 32'd0);
    check("abort_count", 32'(frame_count), 32'd2);
    check("abort_ovr_held", {31'd0, overrun_err}, 32'd1);
    pulse_start();
    check("restart_count", 32'(frame_count), 32'd0);
    check("restart_ovr", {31'd0, overrun_err}, 32'd0);

    // marker wrong on frames 0 and 1
    wait_until(0, "mk_ready");
    strobe_pulse(1, 2);
    check("marker_err0", {31'd0, marker_err}, 32'd1);
    wait_until(1, "mk_readout");
    wait_until(0, "mk_ready2");
    strobe_pulse(0, 2);
    check("marker_err1", {31'd0, marker_err}, 32'd1);
    pulse_abort();

    // async reset mid-EXPOSE
    pulse_start();
    wait_until(0, "rs_ready");
    strobe_pulse(-1, 1);
    tick(2);
    #3 reset_n = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick(2);
    check("post_reset", 32'(dut_vec()), 32'd0);
    pulse_start();
    frames_loop(NF);
    wait_until(2, "rs_done");
    check("rs_count", 32'(frame_count), NF);
    check("rs_flags", {30'd0, overrun_err, marker_err}, 32'd0);

    // random soup: short then long strobe gaps so timeouts also occur
    hold = 1;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) marker_in = ~marker_in;
      hold--;
      if (hold <= 0) begin
        strobe_in = ~strobe_in;
        hold = $urandom_range(1, (i < 1500) ? 8 : 150);
      end
      tick(1);
    end
    start = 1'b0; strobe_in = 1'b0; marker_in = 1'b0;
    pulse_abort();
    tick(3);
    check("final_idle", {30'd0, busy, trigger_out}, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end
endmodule

// File: doc/cam_sync_responder.md
Name: cam_sync_responder

Overview:
- Camera/host end of the projector–camera sync handshake; the counterpart of the pattern-projector controller.
- Drives the trigger and frame-ready lines into the projector. Receives the projector's exposure strobe (VS-gated) and its group marker (high once per 8-frame phase group).
- Sequences one exposure/readout per strobe and counts captured frames up to a full pattern set.
- Flags timeout, overrun and marker-alignment errors.

Parameters:
- NUM_FRAMES, 488, frames per full pattern set (480 fringe + 8 offset).
- EXPOSURE_CYCLES, 50000, clocks frame_ready_out stays high after a strobe edge (1 ms @ 50 MHz).
- READOUT_CYCLES, 100000, clocks frame_ready_out is held low after exposure.
- ARM_CYCLES, 16, clocks between trigger_out rising and frame_ready_out rising.
- TIMEOUT_CYCLES, 5000000, maximum clocks waiting for a strobe edge.
- MARKER_PHASE, 1, frame_count mod 8 value at which marker_in must be high.

Ports:
- CLOCK_50, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a run.
- abort, input, 1, one-cycle pulse; returns the block to IDLE.
- strobe_in, input, 1, exposure strobe from the projector; asynchronous.
- marker_in, input, 1, group marker from the projector; asynchronous.
- trigger_out, output, 1, to projector trigger input; high = run active.
- frame_ready_out, output, 1, to projector frame-ready input; high = camera ready.
- capture, output, 1, one-cycle pulse per accepted strobe.
- frame_count, output, 16, frames completed in the current run.
- busy, output, 1, high in ARM, WAIT_STROBE, EXPOSE and READOUT.
- done, output, 1, high in DONE.
- timeout_err, output, 1, high in ERROR.
- overrun_err, output, 1, sticky; strobe edge seen during EXPOSE or READOUT.
- marker_err, output, 1, sticky; marker mismatch at an accepted strobe.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 and all counters 0.
- Input synchronisation: strobe_in and marker_in each pass through 2 flops. A strobe edge is the synced rising edge, a 1-cycle event 3 clocks after the input rises. Marker is sampled from its synced value in the same cycle as the edge.
- State machine:
  - IDLE: trigger_out=0, frame_ready_out=0. start → ARM; frame_count cleared; overrun_err and marker_err cleared.
  - ARM: trigger_out=1. Hold ARM_CYCLES clocks, then → WAIT_STROBE.
  - WAIT_STROBE: trigger_out=1, frame_ready_out=1. Timeout counter increments each clock.
    - Strobe edge → EXPOSE; capture=1 in the first EXPOSE cycle; timeout counter cleared.
    - Counter reaching TIMEOUT_CYCLES → ERROR.
  - EXPOSE: frame_ready_out=1 for EXPOSURE_CYCLES clocks, then → READOUT.
  - READOUT: frame_ready_out=0 for READOUT_CYCLES clocks. On exit, frame_count increments. If the new count equals NUM_FRAMES → DONE, else → WAIT_STROBE.
  - DONE: trigger_out=0, frame_ready_out=0, done=1, frame_count held. start → ARM (new run).
  - ERROR: trigger_out=0, frame_ready_out=0, timeout_err=1, frame_count held. start → ARM.
- Marker check: at each accepted strobe edge, expected = (frame_count mod 8 == MARKER_PHASE). If the sampled marker differs, marker_err sets. It is sticky, does not change state, and clears only on start.
- Strobe edge during EXPOSE or READOUT: ignored for sequencing, sets overrun_err (sticky).
- Strobe edge in IDLE, ARM, DONE or ERROR: ignored, no flag.
- Priority: abort > timeout > strobe edge > counter expiry. abort in any state → IDLE next clock with trigger_out and frame_ready_out low. frame_count and the sticky flags are held until the next start.
- start outside IDLE, DONE or ERROR is ignored. start and abort in the same cycle: abort wins.
- Counter widths: phase and timeout counters are 32-bit, load 0 on state entry, and compare with ==. frame_count is 16-bit and never wraps within a run, since NUM_FRAMES ≤ 65535.
- Reset mid-run: outputs drop to 0 asynchronously. No partial frame is counted.

Test Plan:
- Nominal run: NUM_FRAMES=3, EXPOSURE=10, READOUT=20, ARM=4; start, then 3 strobes spaced 50 clocks → 3 capture pulses; frame_count 1,2,3; done=1; trigger_out=0 after the last READOUT; no error flags.
- Timeout: TIMEOUT_CYCLES=100; start, no strobe → timeout_err=1 exactly 100 clocks after WAIT_STROBE entry; outputs low; a later start clears it and re-arms.
- Overrun: strobe pulse 5 clocks into EXPOSE → overrun_err=1; frame_count still advances by exactly 1 per accepted strobe.
- Marker: marker_in high at frame 0 and low at frame 1 with MARKER_PHASE=1 → marker_err=1 after the first strobe; correct marker on all frames → marker_err=0.
- Abort mid-READOUT at frame_count=2 → next clock IDLE; trigger_out=0, frame_ready_out=0, frame_count=2 held; start → frame_count=0.
- Async reset asserted mid-EXPOSE between clock edges → all outputs 0 immediately; after release, state IDLE and start behaves as in the nominal run.
